// File: rtl/vector_loader.sv
// rtl/vector_loader.sv - Assembles a serial element stream into flattened A/B vectors held until acknowledged.
// Optional restart input enabled by defining VECTOR_LOADER_ABORT_EN.
module vector_loader #(
    parameter int MATRIXSIZE = 10,
    parameter int INTSIZE    = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [0:INTSIZE-1]                in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [0:INTSIZE*MATRIXSIZE-1]     a_flat,
    output logic [0:INTSIZE*MATRIXSIZE-1]     b_flat,
    output logic                              vec_valid,
    input  logic                              vec_ack,
`ifdef VECTOR_LOADER_ABORT_EN
    input  logic                              abort,
`endif
    output logic [$clog2(MATRIXSIZE)-1:0]     idx
);

    localparam int IDX_W = $clog2(MATRIXSIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIXSIZE - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [IDX_W-1:0]                r_idx;
    logic [IDX_W-1:0]                w_idx_next;
    logic                            r_in_ready;
    logic [0:INTSIZE*MATRIXSIZE-1]   r_a_flat;
    logic [0:INTSIZE*MATRIXSIZE-1]   r_b_flat;
    logic                            w_abort;
    logic                            w_xfer;

`ifdef VECTOR_LOADER_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    // A restart wins over any element offered in the same cycle.
    assign w_xfer = in_valid && r_in_ready && (r_state != HOLD) && !w_abort;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            LOAD_A: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = LOAD_B;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            LOAD_B: begin
                if (w_xfer) begin
                    if (r_idx == LAST_IDX) begin
                        w_idx_next   = '0;
                        w_state_next = HOLD;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            end
            HOLD: begin
                if (vec_ack) begin
                    w_state_next = LOAD_A;
                end
            end
            default: begin
                w_state_next = LOAD_A;
                w_idx_next   = '0;
            end
        endcase
        if (w_abort) begin
            w_state_next = LOAD_A;
            w_idx_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= LOAD_A;
            r_idx      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_in_ready <= (w_state_next != HOLD);
        end
    end

    // Buses are overwritten in place; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_flat <= '0;
            r_b_flat <= '0;
        end else begin
            for (int i = 0; i < MATRIXSIZE; i++) begin
                if (w_xfer && (r_idx == IDX_W'(i))) begin
                    if (r_state == LOAD_A) begin
                        r_a_flat[i*INTSIZE +: INTSIZE] <= in_data;
                    end else begin
                        r_b_flat[i*INTSIZE +: INTSIZE] <= in_data;
                    end
                end
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign vec_valid = (r_state == HOLD);
    assign a_flat    = r_a_flat;
    assign b_flat    = r_b_flat;
    assign idx       = r_idx;

endmodule

// File: tb/tb_vector_loader.sv
// tb/tb_vector_loader.sv - Self-checking bench for vector_loader against an element-count reference model.
module tb_vector_loader;

    localparam int M = 4;
    localparam int W = 8;

    logic             clk;
    logic             rst_n;
    logic [0:W-1]     in_data;
    logic             in_valid;
    logic             in_ready;
    logic [0:W*M-1]   a_flat;
    logic [0:W*M-1]   b_flat;
    logic             vec_valid;
    logic             vec_ack;
    logic             abort_i;
    logic [1:0]       idx;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: count of elements accepted in the current load.
    int         m_cnt;
    logic       m_hold;
    logic       m_rdy;
    logic [7:0] m_a [M];
    logic [7:0] m_b [M];

    vector_loader #(.MATRIXSIZE(M), .INTSIZE(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_flat    (a_flat),
        .b_flat    (b_flat),
        .vec_valid (vec_valid),
        .vec_ack   (vec_ack),
`ifdef VECTOR_LOADER_ABORT_EN
        .abort     (abort_i),
`endif
        .idx       (idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic [7:0] v [M]);
        logic [31:0] r = '0;
        for (int i = 0; i < M; i++) r = (r << 8) | 32'(v[i]);
        return r;
    endfunction

    task automatic model_edge(input logic rst, input logic v, input logic [7:0] d,
                              input logic ack, input logic ab);
        if (!rst) begin
            m_cnt = 0; m_hold = 0; m_rdy = 0;
            for (int i = 0; i < M; i++) begin m_a[i] = '0; m_b[i] = '0; end
        end else if (ab) begin
            m_cnt = 0; m_hold = 0; m_rdy = 1;
        end else if (m_hold) begin
            if (ack) begin m_hold = 0; m_rdy = 1; end
        end else begin
            if (m_rdy && v) begin
                if (m_cnt < M) m_a[m_cnt] = d;
                else           m_b[m_cnt - M] = d;
                m_cnt++;
                if (m_cnt == 2 * M) begin m_cnt = 0; m_hold = 1; end
            end
            m_rdy = !m_hold;
        end
    endtask

    task automatic step(input logic rst, input logic v, input logic [7:0] d,
                        input logic ack, input logic ab);
        @(negedge clk);
        rst_n = rst; in_valid = v; in_data = d; vec_ack = ack; abort_i = ab;
        @(posedge clk);
        #1;
        model_edge(rst, v, d, ack, ab);
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("vec_valid", 64'(vec_valid), 64'(m_hold));
        check("idx", 64'(idx), 64'(m_cnt % M));
        check("a_flat", 64'(a_flat), 64'(pack(m_a)));
        check("b_flat", 64'(b_flat), 64'(pack(m_b)));
    endtask

    initial begin
        logic [7:0] seq [8];
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; vec_ack = 1'b0; abort_i = 1'b0;
        m_cnt = 0; m_hold = 0; m_rdy = 0;
        for (int i = 0; i < M; i++) begin m_a[i] = '0; m_b[i] = '0; end

        // Reset and first cycle after.
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        check("rst_in_ready_low", 64'(in_ready), 64'd0);
        step(1, 0, 8'h00, 0, 0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Back-to-back load.
        seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h0A, 8'h0B, 8'h0C, 8'h0D};
        for (int i = 0; i < 8; i++) step(1, 1, seq[i], 0, 0);
        check("b2b_a", 64'(a_flat), 64'h01020304);
        check("b2b_b", 64'(b_flat), 64'h0A0B0C0D);
        check("b2b_vec_valid", 64'(vec_valid), 64'd1);
        check("b2b_in_ready", 64'(in_ready), 64'd0);

        // Backpressure in HOLD, then ack with data still offered.
        for (int i = 0; i < 5; i++) step(1, 1, 8'hFF, 0, 0);
        check("bp_a_unchanged", 64'(a_flat), 64'h01020304);
        step(1, 1, 8'hFF, 1, 0);
        check("ack_in_ready", 64'(in_ready), 64'd1);
        check("ack_vec_valid", 64'(vec_valid), 64'd0);
        check("ack_a_unchanged", 64'(a_flat), 64'h01020304);
        step(1, 1, 8'hFF, 0, 0);
        check("ff_to_a0", 64'(a_flat), 64'hFF020304);

        // Gapped input, restarting from a clean reset.
        step(0, 0, 8'h00, 0, 0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1, 1, seq[i], 0, 0);
            step(1, 0, 8'h5A, 0, 0);
        end
        check("gap_a", 64'(a_flat), 64'h01020304);
        check("gap_b", 64'(b_flat), 64'h0A0B0C0D);
        step(1, 0, 8'h00, 1, 0);

        // Reset mid-load, then reload 11..18.
        for (int i = 0; i < 5; i++) step(1, 1, 8'h30 + 8'(i), 0, 0);
        step(0, 1, 8'h77, 0, 0);
        check("midrst_idx", 64'(idx), 64'd0);
        step(1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 1, 8'h11 + 8'(i), 0, 0);
        check("reload_a", 64'(a_flat), 64'h11121314);
        check("reload_b", 64'(b_flat), 64'h15161718);

`ifdef VECTOR_LOADER_ABORT_EN
        // Abort in LOAD_B with idx=2 keeps bus contents.
        step(1, 0, 8'h00, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 8'h40 + 8'(i), 0, 0);
        check("pre_abort_idx", 64'(idx), 64'd2);
        step(1, 1, 8'h99, 0, 1);
        check("abort_idx", 64'(idx), 64'd0);
        check("abort_a", 64'(a_flat), 64'h40414243);
        check("abort_b", 64'(b_flat), 64'h44451718);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic r, v, k, ab;
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 3) != 0);
            k  = ($urandom_range(0, 3) == 0);
`ifdef VECTOR_LOADER_ABORT_EN
            ab = ($urandom_range(0, 39) == 0);
`else
            ab = 1'b0;
`endif
            step(r, v, 8'($urandom), k, ab);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
